// File: rtl/param_alu_pkg.sv
// Shared opcode encodings and default widths for the parameterised ALU.
// Values 9..15 extend the original ADD..JZ set, which keeps its codes.
package param_alu_pkg;

  localparam int unsigned DATA_WIDTH   = 8;
  localparam int unsigned ARG_WIDTH    = 8;
  localparam int unsigned OPCODE_WIDTH = 4;

  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_SUB = 1;
  localparam int unsigned OP_LD  = 2;
  localparam int unsigned OP_AND = 3;
  localparam int unsigned OP_OR  = 4;
  localparam int unsigned OP_XOR = 5;
  localparam int unsigned OP_NOT = 6;
  localparam int unsigned OP_JMP = 7;
  localparam int unsigned OP_JZ  = 8;
  localparam int unsigned OP_ADC = 9;
  localparam int unsigned OP_SBB = 10;
  localparam int unsigned OP_SHL = 11;
  localparam int unsigned OP_SHR = 12;
  localparam int unsigned OP_MUL = 13;
  localparam int unsigned OP_JC  = 14;
  localparam int unsigned OP_NOP = 15;

endpackage

// File: rtl/param_alu_if.sv
// Operation request / result bundle between an instruction sequencer and param_alu.
interface param_alu_if #(
  parameter int unsigned DATA_W   = param_alu_pkg::DATA_WIDTH,
  parameter int unsigned ARG_W    = param_alu_pkg::ARG_WIDTH,
  parameter int unsigned OPCODE_W = param_alu_pkg::OPCODE_WIDTH
) ();

  logic                op_valid;
  logic                op_ready;
  logic [OPCODE_W-1:0] opcode;
  logic [DATA_W-1:0]   register;
  logic [ARG_W-1:0]    argument;
  logic [DATA_W-1:0]   acc;
  logic                cy;
  logic                zf;
  logic [ARG_W-1:0]    jmp_addr;
  logic                jmp_ce;
  logic                busy;

  modport master (
    output op_valid, opcode, register, argument,
    input  op_ready, acc, cy, zf, jmp_addr, jmp_ce, busy
  );

  modport slave (
    input  op_valid, opcode, register, argument,
    output op_ready, acc, cy, zf, jmp_addr, jmp_ce, busy
  );

endinterface

// File: rtl/param_alu_mul_seq.sv
// Unsigned shift-add multiplier: one partial product per cycle, DATA_W steps.
// The first step is folded into the start edge so done rises after DATA_W-1 more edges.
module alu_mul_seq #(
  parameter int unsigned DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                done,
  output logic [2*DATA_W-1:0] product
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplier;
  logic [CNT_W-1:0]    cnt;
  logic                run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      run     <= 1'b0;
      done    <= 1'b0;
    end else if (start) begin
      product <= b[0] ? {{DATA_W{1'b0}}, a} : '0;
      mcand   <= {{(DATA_W-1){1'b0}}, a, 1'b0};
      mplier  <= b >> 1;
      cnt     <= CNT_W'(DATA_W - 1);
      run     <= 1'b1;
      done    <= 1'b0;
    end else if (run) begin
      if (mplier[0]) product <= product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        run  <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/param_alu.sv
// Accumulator ALU: single-cycle arithmetic/logic/jump ops plus a
// multi-cycle MUL handled by alu_mul_seq under a three-state FSM.
module param_alu #(
  parameter int unsigned DATA_W   = param_alu_pkg::DATA_WIDTH,
  parameter int unsigned ARG_W    = param_alu_pkg::ARG_WIDTH,
  parameter int unsigned OPCODE_W = param_alu_pkg::OPCODE_WIDTH
) (
  input logic           clk,
  input logic           rst,
  param_alu_if.slave    bus
);

  import param_alu_pkg::*;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_MUL_RUN  = 2'd1;
  localparam logic [1:0] ST_MUL_DONE = 2'd2;

  logic [1:0]          state;
  logic [DATA_W-1:0]   acc_q;
  logic                cy_q;
  logic                zf_q;
  logic [ARG_W-1:0]    jmp_addr_q;
  logic                jmp_ce_q;

  logic [31:0]         op_sel;
  logic [DATA_W-1:0]   nxt_acc;
  logic                nxt_cy;
  logic                acc_we;
  logic                is_mul;
  logic                take_jmp;
  logic                accept;
  logic                mul_done;
  logic [2*DATA_W-1:0] product;

  assign op_sel = 32'(bus.opcode);
  assign accept = bus.op_valid && (state == ST_IDLE);

  always_comb begin
    nxt_acc  = acc_q;
    nxt_cy   = cy_q;
    acc_we   = 1'b0;
    is_mul   = 1'b0;
    take_jmp = 1'b0;
    case (op_sel)
      OP_ADD: begin
        {nxt_cy, nxt_acc} = {1'b0, acc_q} + {1'b0, bus.register};
        acc_we = 1'b1;
      end
      OP_ADC: begin
        {nxt_cy, nxt_acc} = {1'b0, acc_q} + {1'b0, bus.register} + (DATA_W+1)'(cy_q);
        acc_we = 1'b1;
      end
      // Bit DATA_W of the extended difference is the borrow.
      OP_SUB: begin
        {nxt_cy, nxt_acc} = {1'b0, acc_q} - {1'b0, bus.register};
        acc_we = 1'b1;
      end
      OP_SBB: begin
        {nxt_cy, nxt_acc} = {1'b0, acc_q} - {1'b0, bus.register} - (DATA_W+1)'(cy_q);
        acc_we = 1'b1;
      end
      OP_LD:  begin nxt_acc = bus.register;         nxt_cy = 1'b0; acc_we = 1'b1; end
      OP_AND: begin nxt_acc = acc_q & bus.register; nxt_cy = 1'b0; acc_we = 1'b1; end
      OP_OR:  begin nxt_acc = acc_q | bus.register; nxt_cy = 1'b0; acc_we = 1'b1; end
      OP_XOR: begin nxt_acc = acc_q ^ bus.register; nxt_cy = 1'b0; acc_we = 1'b1; end
      OP_NOT: begin nxt_acc = ~bus.register;        nxt_cy = 1'b0; acc_we = 1'b1; end
      OP_SHL: begin {nxt_cy, nxt_acc} = {acc_q, 1'b0}; acc_we = 1'b1; end
      OP_SHR: begin {nxt_acc, nxt_cy} = {1'b0, acc_q}; acc_we = 1'b1; end
      OP_MUL: is_mul = 1'b1;
      OP_JMP: take_jmp = 1'b1;
      OP_JZ:  take_jmp = zf_q;
      OP_JC:  take_jmp = cy_q;
      default: begin nxt_cy = 1'b0; acc_we = 1'b1; end
    endcase
  end

  alu_mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_mul),
    .a       (acc_q),
    .b       (bus.register),
    .done    (mul_done),
    .product (product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      acc_q      <= '0;
      cy_q       <= 1'b0;
      zf_q       <= 1'b1;
      jmp_ce_q   <= 1'b0;
      jmp_addr_q <= '0;
    end else begin
      jmp_ce_q   <= 1'b0;
      jmp_addr_q <= '0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state <= ST_MUL_RUN;
            end else if (acc_we) begin
              acc_q <= nxt_acc;
              cy_q  <= nxt_cy;
              zf_q  <= (nxt_acc == '0);
            end
            if (take_jmp) begin
              jmp_ce_q   <= 1'b1;
              jmp_addr_q <= bus.argument;
            end
          end
        end
        ST_MUL_RUN: begin
          if (mul_done) state <= ST_MUL_DONE;
        end
        ST_MUL_DONE: begin
          acc_q <= product[DATA_W-1:0];
          cy_q  <= |product[2*DATA_W-1:DATA_W];
          zf_q  <= (product[DATA_W-1:0] == '0);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.op_ready = (state == ST_IDLE);
  assign bus.busy     = (state != ST_IDLE);
  assign bus.acc      = acc_q;
  assign bus.cy       = cy_q;
  assign bus.zf       = zf_q;
  assign bus.jmp_ce   = jmp_ce_q;
  assign bus.jmp_addr = jmp_addr_q;

endmodule

// File: tb/tb_param_alu.sv
// Randomised self-checking bench for param_alu (DATA_W=8) with a DATA_W=16 regression instance.
module tb_param_alu;

  import param_alu_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  param_alu_if #(.DATA_W(8),  .ARG_W(8), .OPCODE_W(4)) bus8 ();
  param_alu_if #(.DATA_W(16), .ARG_W(8), .OPCODE_W(4)) bus16 ();

  param_alu #(.DATA_W(8),  .ARG_W(8), .OPCODE_W(4)) dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
  param_alu #(.DATA_W(16), .ARG_W(8), .OPCODE_W(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference state for the 8-bit instance
  int m_acc, m_cy, m_jce, m_jaddr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input int op, input int r, input int a);
    int t;
    m_jce   = 0;
    m_jaddr = 0;
    case (op)
      OP_ADD: begin t = m_acc + r;        m_cy = int'(t > 255); m_acc = t % 256; end
      OP_ADC: begin t = m_acc + r + m_cy; m_cy = int'(t > 255); m_acc = t % 256; end
      OP_SUB: begin t = m_acc - r;        m_cy = int'(t < 0);   m_acc = (t + 512) % 256; end
      OP_SBB: begin t = m_acc - r - m_cy; m_cy = int'(t < 0);   m_acc = (t + 512) % 256; end
      OP_LD:  begin m_acc = r;           m_cy = 0; end
      OP_AND: begin m_acc = m_acc & r;   m_cy = 0; end
      OP_OR:  begin m_acc = m_acc | r;   m_cy = 0; end
      OP_XOR: begin m_acc = m_acc ^ r;   m_cy = 0; end
      OP_NOT: begin m_acc = 255 - r;     m_cy = 0; end
      OP_SHL: begin m_cy = m_acc / 128;  m_acc = (m_acc * 2) % 256; end
      OP_SHR: begin m_cy = m_acc % 2;    m_acc = m_acc / 2; end
      OP_MUL: begin t = m_acc * r; m_acc = t % 256; m_cy = int'((t / 256) != 0); end
      OP_JMP: begin m_jce = 1; m_jaddr = a; end
      OP_JZ:  if (m_acc == 0) begin m_jce = 1; m_jaddr = a; end
      OP_JC:  if (m_cy == 1)  begin m_jce = 1; m_jaddr = a; end
      default: m_cy = 0;
    endcase
  endfunction

  task automatic chk_state(input string tag);
    chk({tag, ".acc"},      32'(bus8.acc),      32'(m_acc));
    chk({tag, ".cy"},       32'(bus8.cy),       32'(m_cy));
    chk({tag, ".zf"},       32'(bus8.zf),       32'(m_acc == 0));
    chk({tag, ".jmp_ce"},   32'(bus8.jmp_ce),   32'(m_jce));
    chk({tag, ".jmp_addr"}, 32'(bus8.jmp_addr), 32'(m_jaddr));
    chk({tag, ".op_ready"}, 32'(bus8.op_ready), 32'd1);
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    bus8.op_valid = 1'b0;
    bus8.opcode   = 4'($urandom_range(0, 15));
    bus8.register = 8'($urandom);
    @(posedge clk); #1;
    m_jce   = 0;
    m_jaddr = 0;
    chk_state(tag);
  endtask

  task automatic issue(input string tag, input int op, input int r, input int a);
    int old_acc, old_cy, low_cnt;
    old_acc = m_acc;
    old_cy  = m_cy;
    @(negedge clk);
    bus8.op_valid = 1'b1;
    bus8.opcode   = 4'(op);
    bus8.register = 8'(r);
    bus8.argument = 8'(a);
    model(op, r, a);
    @(posedge clk); #1;
    if (op == int'(OP_MUL)) begin
      low_cnt = 0;
      for (int i = 0; i < 9; i++) begin
        if (bus8.op_ready == 1'b0 && bus8.busy == 1'b1 &&
            int'(bus8.acc) == old_acc && int'(bus8.cy) == old_cy) low_cnt++;
        // Offered ops while busy must be dropped, not queued
        @(negedge clk);
        bus8.op_valid = (i < 8);
        bus8.opcode   = 4'(OP_ADD);
        bus8.register = 8'($urandom);
        @(posedge clk); #1;
      end
      chk({tag, ".mul_busy_cycles"}, 32'(low_cnt), 32'd9);
    end
    chk_state(tag);
  endtask

  initial begin
    int op;
    int low16;
    rst = 1'b1;
    bus8.op_valid  = 1'b0; bus8.opcode  = '0; bus8.register  = '0; bus8.argument  = '0;
    bus16.op_valid = 1'b0; bus16.opcode = '0; bus16.register = '0; bus16.argument = '0;
    m_acc = 0; m_cy = 0; m_jce = 0; m_jaddr = 0;
    #1;
    chk_state("reset");
    chk("reset.busy",    32'(bus8.busy),  32'd0);
    chk("reset16.acc",   32'(bus16.acc),  32'd0);
    chk("reset16.zf",    32'(bus16.zf),   32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Carry out of ADD, then ADC consumes it
    issue("ld_f0", OP_LD, 'hF0, 0);
    issue("add_20", OP_ADD, 'h20, 0);
    chk("add_20.lit_acc", 32'(bus8.acc), 32'h10);
    chk("add_20.lit_cy",  32'(bus8.cy),  32'd1);
    issue("adc_00", OP_ADC, 'h00, 0);
    chk("adc_00.lit_acc", 32'(bus8.acc), 32'h11);
    chk("adc_00.lit_cy",  32'(bus8.cy),  32'd0);

    // Borrow, then shift right out of bit 0
    issue("ld_05", OP_LD, 'h05, 0);
    issue("sub_06", OP_SUB, 'h06, 0);
    chk("sub_06.lit_acc", 32'(bus8.acc), 32'hFF);
    chk("sub_06.lit_cy",  32'(bus8.cy),  32'd1);
    issue("shr", OP_SHR, 0, 0);
    chk("shr.lit_acc", 32'(bus8.acc), 32'h7F);
    chk("shr.lit_cy",  32'(bus8.cy),  32'd1);

    // JZ taken then not taken; pulse lasts exactly one cycle
    issue("ld_00", OP_LD, 'h00, 0);
    issue("jz_taken", OP_JZ, 0, 'h3C);
    chk("jz_taken.lit_ce",   32'(bus8.jmp_ce),   32'd1);
    chk("jz_taken.lit_addr", 32'(bus8.jmp_addr), 32'h3C);
    idle("jz_after");
    issue("ld_01", OP_LD, 'h01, 0);
    issue("jz_not", OP_JZ, 0, 'h3C);
    chk("jz_not.lit_ce", 32'(bus8.jmp_ce), 32'd0);

    // Multicycle multiply with ignored offers, then multiply by zero
    issue("ld_12", OP_LD, 'h12, 0);
    issue("mul_10", OP_MUL, 'h10, 0);
    chk("mul_10.lit_acc", 32'(bus8.acc), 32'h20);
    chk("mul_10.lit_cy",  32'(bus8.cy),  32'd1);
    issue("ld_37", OP_LD, 'h37, 0);
    issue("mul_00", OP_MUL, 'h00, 0);
    chk("mul_00.lit_zf", 32'(bus8.zf), 32'd1);
    issue("nop", OP_NOP, 'hAA, 0);

    // Reset 3 cycles into a multiply aborts it; first edge after release accepts
    issue("ld_12b", OP_LD, 'h12, 0);
    @(negedge clk);
    bus8.op_valid = 1'b1; bus8.opcode = 4'(OP_MUL); bus8.register = 8'h10;
    @(posedge clk);
    @(negedge clk);
    bus8.op_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid.acc",  32'(bus8.acc),  32'd0);
    chk("rst_mid.zf",   32'(bus8.zf),   32'd1);
    chk("rst_mid.busy", 32'(bus8.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus8.op_valid = 1'b1; bus8.opcode = 4'(OP_LD); bus8.register = 8'h55;
    m_acc = 'h55; m_cy = 0; m_jce = 0; m_jaddr = 0;
    @(posedge clk); #1;
    chk("rst_ld55.acc", 32'(bus8.acc), 32'h55);
    for (int i = 0; i < 12; i++) idle("rst_no_stale");

    // Random operation stream against the reference model
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle("rnd_idle");
      end else begin
        op = int'($urandom_range(0, 15));
        issue("rnd", op, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      end
    end

    // 16-bit regression instance
    @(negedge clk);
    bus8.op_valid  = 1'b0;
    bus16.op_valid = 1'b1; bus16.opcode = 4'(OP_LD); bus16.register = 16'hFFFF;
    @(posedge clk); #1;
    @(negedge clk);
    bus16.opcode = 4'(OP_ADD); bus16.register = 16'h0001;
    @(posedge clk); #1;
    chk("w16_add.acc", 32'(bus16.acc), 32'h0000);
    chk("w16_add.cy",  32'(bus16.cy),  32'd1);
    chk("w16_add.zf",  32'(bus16.zf),  32'd1);
    @(negedge clk);
    bus16.opcode = 4'(OP_LD); bus16.register = 16'h0300;
    @(posedge clk); #1;
    @(negedge clk);
    bus16.opcode = 4'(OP_MUL); bus16.register = 16'h0102;
    @(posedge clk); #1;
    low16 = 0;
    for (int i = 0; i < 17; i++) begin
      if (bus16.op_ready == 1'b0 && bus16.acc == 16'h0300) low16++;
      @(negedge clk);
      bus16.op_valid = 1'b0;
      @(posedge clk); #1;
    end
    chk("w16_mul.busy_cycles", 32'(low16), 32'd17);
    chk("w16_mul.acc", 32'(bus16.acc), 32'h0600);
    chk("w16_mul.cy",  32'(bus16.cy),  32'd1);
    chk("w16_mul.zf",  32'(bus16.zf),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
